read_controller: RTL and testbench
==================================

READ_CONTROLLER -- requirements
Module: READ_CONTROLLER

Interface
REQ-001 Parameter WL, default 28, SHALL set the width in bits of one stored line word.
REQ-002 Parameter DEPTH, default 36, SHALL set the number of words read per frame.
REQ-003 Parameter AW, default 6, SHALL set the read-address width.
REQ-004 iCLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 iRSTn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 iCLR  in  1  SHALL be a synchronous clear, active-high.
REQ-007 iSTART  in  1  SHALL be a one-cycle frame-ready pulse from the write stage's done output.
REQ-008 oRd_EN  out  1  SHALL be the buffer-memory read strobe.
REQ-009 oRd_ADDR  out  AW  SHALL be the buffer-memory read address.
REQ-010 iRd_DATA  in  WL  SHALL be memory read data, valid exactly one cycle after oRd_EN.
REQ-011 oDATA  out  WL  SHALL be the streamed word to the downstream engine.
REQ-012 oVALID  out  1  SHALL indicate that oDATA holds a word not yet accepted.
REQ-013 iREADY  in  1  SHALL be the downstream accept signal; a transfer occurs when oVALID and iREADY are both high.
REQ-014 oBUSY  out  1  SHALL be high whenever the state is not IDLE.
REQ-015 oRd_DONE  out  1  SHALL be a one-cycle frame-complete pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-017 IDLE->READ SHALL occur on iSTART; iSTART in any other state SHALL be ignored.
REQ-018 In READ, oRd_EN SHALL assert when fewer than DEPTH reads have been issued and (FIFO count + reads in flight - pop this cycle) < 2.
REQ-019 oRd_ADDR SHALL start at 0 and increment by 1 after each issued read, reaching DEPTH-1 on the last read.
REQ-020 READ->DRAIN SHALL occur in the cycle after the read to address DEPTH-1 is issued.
REQ-021 DRAIN->DONE SHALL occur when the FIFO is empty and no read is in flight.
REQ-022 DONE SHALL last exactly one cycle with oRd_DONE=1, then return to IDLE.
REQ-023 iRd_DATA SHALL be pushed into a 2-entry output FIFO in the cycle after its oRd_EN; the FIFO SHALL never overflow.
REQ-024 oDATA SHALL be the registered FIFO head, and oVALID SHALL equal FIFO non-empty.
REQ-025 oDATA SHALL hold its value while oVALID=1 and iREADY=0.
REQ-026 Latency: oRd_EN SHALL be high in the cycle after iSTART, and the first oVALID SHALL follow two cycles later.
REQ-027 With iREADY held at 1, throughput SHALL be one word per cycle, with no bubbles after the first word.
REQ-028 Words SHALL leave in address order 0..DEPTH-1, with no drops or duplicates under any iREADY pattern.
REQ-029 A simultaneous push and pop on a full FIFO SHALL be legal, and the count SHALL remain unchanged.
REQ-030 iCLR SHALL have priority over every other input: state to IDLE, FIFO flushed, in-flight read discarded, all outputs to their reset values on the next edge.
REQ-031 An iCLR and iSTART in the same cycle SHALL result in IDLE.

Reset
REQ-032 On iRSTn low, outputs SHALL reset asynchronously to: oRd_EN=0, oRd_ADDR=0, oDATA=0, oVALID=0, oBUSY=0, oRd_DONE=0.
REQ-033 On iRSTn low, the state SHALL be IDLE and the FIFO count and in-flight flag SHALL be 0.
REQ-034 A reset asserted mid-frame SHALL abandon the frame; no oRd_DONE SHALL follow.

Structure
REQ-035 The defaults for WL, DEPTH and AW and the state encodings SHALL live in the shared parameter include used by the write and read stages.
REQ-036 The address counter SHALL be an instance of the existing COUNTER_NECV (WL=AW, IV=0) enabled by oRd_EN and cleared by iCLR or DONE; the FIFO and FSM SHALL stay inline.

Verification
REQ-037 Scenario: reset, then iSTART at cycle 0 with iREADY=1 -> oRd_EN in cycles 1..36 (addresses 0..35), oVALID in cycles 3..38, oRd_DONE in cycle 39, oBUSY low in cycle 40.
REQ-038 Scenario: memory word n = n*0x0100001, iREADY toggled 1,0,1,0 -> the 36 accepted words equal 0x0000000..0x2300023 in order, and oDATA is stable while stalled.
REQ-039 Scenario: iREADY=0 for 10 cycles after iSTART -> exactly 2 reads issued, oRd_ADDR=2, FIFO full; releasing iREADY resumes the stream without loss.
REQ-040 Scenario: iCLR pulsed after the 17th transfer -> on the next edge the state is IDLE and all outputs are 0; a new iSTART restarts from address 0.
REQ-041 Scenario: iSTART re-pulsed during READ and DRAIN -> ignored; exactly 36 words and one oRd_DONE.
REQ-042 Scenario: iRSTn low mid-DRAIN -> outputs 0 immediately, without waiting for a clock edge, and no oRd_DONE.

Source files
------------

// File: rtl/read_controller_pkg.sv
// Shared defaults and state encoding for the frame buffer write/read stages.
package read_controller_pkg;

  localparam int WL_DEF    = 28;
  localparam int DEPTH_DEF = 36;
  localparam int AW_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/read_controller_counter.sv
// Up-counter with enable and synchronous clear to IV; clear wins over enable.
module read_controller_counter #(
  parameter int WL = 6,
  parameter int IV = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [WL-1:0] cnt_o
);

  logic [WL-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = WL'(IV);
    else if (en_i) cnt_d = cnt_q + WL'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= WL'(IV);
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/read_controller.sv
// Streams one frame of DEPTH words from buffer memory through a 2-entry output FIFO.
// state | meaning: IDLE wait iSTART; READ issue reads; DRAIN empty FIFO; DONE 1-cycle pulse
module read_controller
  import read_controller_pkg::*;
#(
  parameter int WL    = WL_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iCLR,
  input  logic          iSTART,
  output logic          oRd_EN,
  output logic [AW-1:0] oRd_ADDR,
  input  logic [WL-1:0] iRd_DATA,
  output logic [WL-1:0] oDATA,
  output logic          oVALID,
  input  logic          iREADY,
  output logic          oBUSY,
  output logic          oRd_DONE
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH-1);

  rd_state_e     state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, rd_ptr_q;
  logic [WL-1:0] mem_q [2];
  logic          push, pop, cnt_clr;
  logic [2:0]    occ;

  assign push    = inflight_q;
  assign oVALID  = (count_q != 2'd0);
  assign pop     = oVALID & iREADY;
  // Slots committed next cycle; a pop this cycle frees one, keeping the bubble-free stream.
  assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign cnt_clr = iCLR | (state_q == ST_DONE);

  always_comb begin
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (iCLR) count_d = 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    oRd_EN     = 1'b0;
    inflight_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (iSTART) state_d = ST_READ;
      ST_READ: begin
        if (({1'b0, oRd_ADDR} < DEPTH_W) && (occ < 3'd2)) oRd_EN = 1'b1;
        if (oRd_EN && (oRd_ADDR == LAST_A)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (count_d == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    inflight_d = oRd_EN;
    if (iCLR) begin
      state_d    = ST_IDLE;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (iCLR) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= iRd_DATA;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign oDATA    = mem_q[rd_ptr_q];
  assign oBUSY    = (state_q != ST_IDLE);
  assign oRd_DONE = (state_q == ST_DONE);

  read_controller_counter #(
    .WL(AW),
    .IV(0)
  ) u_addr_cnt (
    .clk_i (iCLK),
    .rst_ni(iRSTn),
    .clr_i (cnt_clr),
    .en_i  (oRd_EN),
    .cnt_o (oRd_ADDR)
  );

endmodule

// File: tb/tb_read_controller.sv
// Bench for read_controller: memory model, scoreboard of words by address order, frame scenarios.
module tb_read_controller;

  localparam int WL    = 28;
  localparam int DEPTH = 36;
  localparam int AW    = 6;

  logic          iCLK = 1'b0;
  logic          iRSTn = 1'b0;
  logic          iCLR = 1'b0;
  logic          iSTART = 1'b0;
  logic          iREADY = 1'b0;
  logic [WL-1:0] iRd_DATA = '0;
  logic          oRd_EN, oVALID, oBUSY, oRd_DONE;
  logic [AW-1:0] oRd_ADDR;
  logic [WL-1:0] oDATA;

  int total = 0;
  int bad   = 0;

  int            issued, accepted, done_cnt;
  logic          held_v;
  logic [WL-1:0] held_d;
  logic [WL-1:0] salt = '0;
  int            rdy_mode, rdy_pct;
  logic          pop_now;

  read_controller #(.WL(WL), .DEPTH(DEPTH), .AW(AW)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iSTART(iSTART),
    .oRd_EN(oRd_EN), .oRd_ADDR(oRd_ADDR), .iRd_DATA(iRd_DATA),
    .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
    .oBUSY(oBUSY), .oRd_DONE(oRd_DONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WL-1:0] word(input int n);
    logic [31:0] v;
    v = n * 32'h0100001;
    return v[WL-1:0] ^ salt;
  endfunction

  // Memory answers one cycle after the strobe.
  always @(posedge iCLK) if (oRd_EN) iRd_DATA <= word(int'(oRd_ADDR));

  always @(negedge iCLK) begin
    pop_now = oVALID && iREADY;
    if (oRd_EN) begin
      chk("rd_addr", 64'(oRd_ADDR), 64'(issued));
      chk("rd_cnt", 64'(issued < DEPTH), 64'd1);
      chk("occ", 64'((issued + int'(oRd_EN) - accepted - int'(pop_now)) <= 2), 64'd1);
      issued++;
    end
    if (oVALID && held_v) chk("hold", 64'(oDATA), 64'(held_d));
    if (pop_now) begin
      chk("data", 64'(oDATA), 64'(word(accepted)));
      chk("dup", 64'(accepted < DEPTH), 64'd1);
      accepted++;
    end
    held_v = oVALID && !iREADY;
    held_d = oDATA;
    if (oRd_DONE) begin
      chk("done_all", 64'(accepted), 64'(DEPTH));
      done_cnt++;
    end
  end

  task automatic reset_model();
    issued   = 0;
    accepted = 0;
    held_v   = 1'b0;
  endtask

  task automatic step();
    @(posedge iCLK); #1;
    case (rdy_mode)
      0: iREADY = 1'b1;
      1: iREADY = ~iREADY;
      2: iREADY = ($urandom_range(99) < rdy_pct);
      default: iREADY = 1'b0;
    endcase
  endtask

  task automatic start();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk("timeout", 64'(done_cnt != d0), 64'd1);
    step();
    step();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    int d0, n;
    done_cnt = 0;
    reset_model();
    rdy_mode = 0;
    rdy_pct  = 50;

    #3;
    chk("rst_ctl", 64'({oRd_EN, oVALID, oRd_DONE, oBUSY}), 64'd0);
    chk("rst_addr", 64'(oRd_ADDR), 64'd0);
    chk("rst_data", 64'(oDATA), 64'd0);
    @(posedge iCLK); @(posedge iCLK); #1;
    iRSTn = 1'b1;
    step();

    // Exact timeline with iREADY held high.
    reset_model();
    iREADY = 1'b1;
    iSTART = 1'b1;
    @(negedge iCLK);
    chk("t0", 64'({oRd_EN, oVALID, oRd_DONE, oBUSY}), 64'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      @(negedge iCLK);
      e = {c <= 36, (c >= 3) && (c <= 38), c == 39, c <= 39};
      chk("tline", 64'({oRd_EN, oVALID, oRd_DONE, oBUSY}), 64'(e));
      if (c <= 36) chk("tline_addr", 64'(oRd_ADDR), 64'(c - 1));
    end
    @(posedge iCLK); #1;
    chk("tline_done", 64'(done_cnt), 64'd1);
    chk("tline_words", 64'(accepted), 64'(DEPTH));

    // Alternating accept pattern, plain data ramp.
    reset_model();
    rdy_mode = 1;
    iREADY   = 1'b0;
    start();
    run_until_done(300);
    chk("tgl_words", 64'(accepted), 64'(DEPTH));
    chk("tgl_done", 64'(done_cnt), 64'd2);

    // Downstream stalled for 10 cycles.
    reset_model();
    rdy_mode = 3;
    iREADY   = 1'b0;
    start();
    for (int i = 0; i < 9; i++) step();
    chk("stall_issued", 64'(issued), 64'd2);
    chk("stall_addr", 64'(oRd_ADDR), 64'd2);
    chk("stall_valid", 64'({oVALID, oBUSY}), 64'b11);
    chk("stall_acc", 64'(accepted), 64'd0);
    rdy_mode = 0;
    run_until_done(200);
    chk("stall_words", 64'(accepted), 64'(DEPTH));

    // Clear after the 17th transfer, then restart.
    reset_model();
    rdy_mode = 0;
    d0 = done_cnt;
    start();
    n = 0;
    while (accepted < 17 && n < 100) begin step(); n++; end
    chk("clr_reach", 64'(accepted >= 17), 64'd1);
    iCLR = 1'b1;
    @(posedge iCLK); #1;
    iCLR = 1'b0;
    chk("clr_ctl", 64'({oRd_EN, oVALID, oRd_DONE, oBUSY}), 64'd0);
    chk("clr_addr", 64'(oRd_ADDR), 64'd0);
    chk("clr_data", 64'(oDATA), 64'd0);
    step();
    chk("clr_nodone", 64'(done_cnt), 64'(d0));
    reset_model();
    salt     = WL'($urandom);
    rdy_mode = 2;
    rdy_pct  = 60;
    start();
    run_until_done(400);
    chk("clr_restart", 64'(accepted), 64'(DEPTH));

    // Clear and start together stay idle.
    reset_model();
    iCLR   = 1'b1;
    iSTART = 1'b1;
    step();
    iCLR   = 1'b0;
    iSTART = 1'b0;
    chk("clrstart_busy", 64'(oBUSY), 64'd0);
    step();
    chk("clrstart_en", 64'({oRd_EN, oBUSY}), 64'd0);

    // Re-pulsed start while busy is ignored.
    reset_model();
    d0       = done_cnt;
    rdy_pct  = 50;
    start();
    n = 0;
    do begin
      step();
      iSTART = (oBUSY && !oRd_DONE) ? 1'($urandom_range(1)) : 1'b0;
      n++;
    end while (done_cnt == d0 && n < 400);
    iSTART = 1'b0;
    step(); step(); step();
    chk("restart_done", 64'(done_cnt), 64'(d0 + 1));
    chk("restart_words", 64'(accepted), 64'(DEPTH));
    chk("restart_idle", 64'(oBUSY), 64'd0);

    // Random frames with random data and accept rates.
    for (int f = 0; f < 3; f++) begin
      reset_model();
      salt     = WL'($urandom);
      rdy_mode = 2;
      rdy_pct  = $urandom_range(20, 90);
      start();
      run_until_done(600);
      chk("rand_words", 64'(accepted), 64'(DEPTH));
    end

    // Asynchronous reset during DRAIN.
    reset_model();
    salt     = '0;
    rdy_mode = 0;
    d0       = done_cnt;
    start();
    n = 0;
    while (!(issued == DEPTH && oBUSY && !oRd_DONE) && n < 100) begin step(); n++; end
    chk("drain_reach", 64'({oBUSY, oVALID}), 64'b11);
    #2;
    iRSTn = 1'b0;
    #1;
    chk("arst_ctl", 64'({oRd_EN, oVALID, oRd_DONE, oBUSY}), 64'd0);
    chk("arst_addr", 64'(oRd_ADDR), 64'd0);
    chk("arst_data", 64'(oDATA), 64'd0);
    step();
    reset_model();
    iRSTn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("arst_nodone", 64'(done_cnt), 64'(d0));
    chk("arst_idle", 64'(oBUSY), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
